// File: rtl/video_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// video_pattern_gen_if
// Video output bundle produced by video_pattern_gen and consumed by the
// display encoder / prefetching memory readers.
//   hs, vs, de          sync pulses and data-enable
//   rgb_r/g/b           8-bit pixel components (zero outside the active area)
//   frame_start         one-cycle pulse on the first active pixel of a frame
//   la_valid/la_x/la_y  look-ahead copy of de/x/y, leading by LOOKAHEAD cycles
// Modports: master = pattern generator (drives), slave = downstream (reads).
// -----------------------------------------------------------------------------
interface video_pattern_gen_if #(
  parameter int CNT_W = 12
);
  logic             hs;
  logic             vs;
  logic             de;
  logic [7:0]       rgb_r;
  logic [7:0]       rgb_g;
  logic [7:0]       rgb_b;
  logic             frame_start;
  logic             la_valid;
  logic [CNT_W-1:0] la_x;
  logic [CNT_W-1:0] la_y;

  modport master (
    output hs, vs, de, rgb_r, rgb_g, rgb_b, frame_start, la_valid, la_x, la_y
  );

  modport slave (
    input hs, vs, de, rgb_r, rgb_g, rgb_b, frame_start, la_valid, la_x, la_y
  );
endinterface

// File: rtl/video_pattern_gen.sv
// -----------------------------------------------------------------------------
// video_pattern_gen
// Parametrised video timing and test-pattern generator. A horizontal/vertical
// counter pair walks the raster (FP, SYNC, BP, ACTIVE in that order on both
// axes); a second pair runs LOOKAHEAD positions ahead and publishes the
// coordinate that will be displayed LOOKAHEAD cycles later.
// Patterns (mode): 0 colour bars, 1 grid, 2 gradient, 3 solid colour. mode and
// solid_rgb are captured only on the last position of a frame.
// Ports:
//   clk        pixel clock
//   rst_n      asynchronous active-low reset
//   mode       pattern select (captured at frame boundary)
//   solid_rgb  {R,G,B} for the solid pattern (captured with mode)
//   vid        video output bundle (master side)
// All outputs are registered: one cycle from counter position to pins.
// -----------------------------------------------------------------------------
module video_pattern_gen #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int GRID      = 32,
  parameter int LOOKAHEAD = 0,
  parameter int CNT_W     = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic [23:0]         solid_rgb,
  video_pattern_gen_if.master vid
);

  localparam int H_BLANK = H_FP + H_SYNC + H_BP;
  localparam int H_TOTAL = H_BLANK + H_ACTIVE;
  localparam int V_BLANK = V_FP + V_SYNC + V_BP;
  localparam int V_TOTAL = V_BLANK + V_ACTIVE;

  // Lead pair start offset; LOOKAHEAD may span several lines.
  localparam int LA_H = LOOKAHEAD % H_TOTAL;
  localparam int LA_V = (LOOKAHEAD / H_TOTAL) % V_TOTAL;

  // Bar width; guarded so a tiny active width still gives a legal counter.
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] H_BLANK_C  = CNT_W'(H_BLANK);
  localparam logic [CNT_W-1:0] V_BLANK_C  = CNT_W'(V_BLANK);
  localparam logic [CNT_W-1:0] X_LAST     = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] G_LAST     = CNT_W'(GRID - 1);
  localparam logic [CNT_W-1:0] BAR_LAST   = CNT_W'(BAR_W - 1);
  localparam logic [CNT_W-1:0] LA_H_C     = CNT_W'(LA_H);
  localparam logic [CNT_W-1:0] LA_V_C     = CNT_W'(LA_V);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  // Colour of bar k: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [23:0] bar_colour(input logic [2:0] k);
    logic [23:0] c;
    case (k)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Saturating bar index step; everything past bar 7 (remainder) stays black.
  function automatic logic [2:0] bar_step(input logic [2:0] k);
    return (k == 3'd7) ? 3'd7 : k + 3'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: raster counters, pattern phase counters, frame-latched controls
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [CNT_W-1:0] lh_cnt, lv_cnt;
  logic [CNT_W-1:0] h_nxt, v_nxt, lh_nxt, lv_nxt;
  logic             h_last, v_last, lh_last, lv_last;
  logic [CNT_W-1:0] gx_ph, gy_ph;
  logic [CNT_W-1:0] bar_cnt;
  logic [2:0]       bar_idx;
  logic [1:0]       mode_r;
  logic [23:0]      solid_r;

  always_comb begin
    h_last  = (h_cnt == H_LAST);
    v_last  = (v_cnt == V_LAST);
    lh_last = (lh_cnt == H_LAST);
    lv_last = (lv_cnt == V_LAST);
    h_nxt   = h_last ? '0 : h_cnt + ONE;
    v_nxt   = v_cnt;
    if (h_last) begin
      v_nxt = v_last ? '0 : v_cnt + ONE;
    end
    lh_nxt  = lh_last ? '0 : lh_cnt + ONE;
    lv_nxt  = lv_cnt;
    if (lh_last) begin
      lv_nxt = lv_last ? '0 : lv_cnt + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      lh_cnt <= LA_H_C;
      lv_cnt <= LA_V_C;
    end else begin
      h_cnt  <= h_nxt;
      v_cnt  <= v_nxt;
      lh_cnt <= lh_nxt;
      lv_cnt <= lv_nxt;
    end
  end

  // Phase counters track x%GRID, y%GRID and the bar index without dividers.
  // They are re-aligned to zero whenever the next position is the first
  // active column/line, so their values during blanking are irrelevant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_ph   <= '0;
      gy_ph   <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
    end else begin
      if (h_nxt == H_BLANK_C || gx_ph == G_LAST) begin
        gx_ph <= '0;
      end else begin
        gx_ph <= gx_ph + ONE;
      end

      if (h_last) begin
        if (v_nxt == V_BLANK_C || gy_ph == G_LAST) begin
          gy_ph <= '0;
        end else begin
          gy_ph <= gy_ph + ONE;
        end
      end

      if (h_nxt == H_BLANK_C) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (bar_cnt == BAR_LAST) begin
        bar_cnt <= '0;
        bar_idx <= bar_step(bar_idx);
      end else begin
        bar_cnt <= bar_cnt + ONE;
      end
    end
  end

  // Pattern selection only changes on the last position of a frame, so the
  // new pattern starts with the first pixel of the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r  <= '0;
      solid_r <= '0;
    end else if (h_last && v_last) begin
      mode_r  <= mode;
      solid_r <= solid_rgb;
    end
  end

  // Position decode for both counter pairs.
  logic             hs_d, vs_d, de_d, fs_d, lde_d;
  logic [CNT_W-1:0] x_d, y_d, lx_d, ly_d;
  logic             grid_on;
  logic [7:0]       xb, yb;
  logic [23:0]      pix_d;

  always_comb begin
    hs_d    = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_d    = (v_cnt >= VS_START) && (v_cnt < VS_END);
    de_d    = (h_cnt >= H_BLANK_C) && (v_cnt >= V_BLANK_C);
    fs_d    = (h_cnt == H_BLANK_C) && (v_cnt == V_BLANK_C);
    x_d     = h_cnt - H_BLANK_C;
    y_d     = v_cnt - V_BLANK_C;
    lde_d   = (lh_cnt >= H_BLANK_C) && (lv_cnt >= V_BLANK_C);
    lx_d    = lh_cnt - H_BLANK_C;
    ly_d    = lv_cnt - V_BLANK_C;
    xb      = 8'(x_d);
    yb      = 8'(y_d);
    grid_on = (gx_ph == '0) || (gy_ph == '0) || (x_d == X_LAST) || (y_d == Y_LAST);
    pix_d   = 24'h000000;
    if (de_d) begin
      case (mode_r)
        2'd0:    pix_d = bar_colour(bar_idx);
        2'd1:    pix_d = grid_on ? 24'hFFFFFF : 24'h000000;
        2'd2:    pix_d = {xb, yb, xb ^ yb};
        default: pix_d = solid_r;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: registered outputs
  // ---------------------------------------------------------------------------
  logic             hs_p1, vs_p1, vld_p1, fs_p1, la_vld_p1;
  logic [23:0]      rgb_p1;
  logic [CNT_W-1:0] la_x_p1, la_y_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p1     <= ~HS_POL;
      vs_p1     <= ~VS_POL;
      vld_p1    <= 1'b0;
      fs_p1     <= 1'b0;
      rgb_p1    <= '0;
      la_vld_p1 <= 1'b0;
      la_x_p1   <= '0;
      la_y_p1   <= '0;
    end else begin
      hs_p1     <= hs_d ? HS_POL : ~HS_POL;
      vs_p1     <= vs_d ? VS_POL : ~VS_POL;
      vld_p1    <= de_d;
      fs_p1     <= fs_d;
      rgb_p1    <= pix_d;
      la_vld_p1 <= lde_d;
      // Coordinates are held through blanking so prefetchers see a stable value.
      if (lde_d) begin
        la_x_p1 <= lx_d;
        la_y_p1 <= ly_d;
      end
    end
  end

  assign vid.hs          = hs_p1;
  assign vid.vs          = vs_p1;
  assign vid.de          = vld_p1;
  assign vid.frame_start = fs_p1;
  assign vid.rgb_r       = rgb_p1[23:16];
  assign vid.rgb_g       = rgb_p1[15:8];
  assign vid.rgb_b       = rgb_p1[7:0];
  assign vid.la_valid    = la_vld_p1;
  assign vid.la_x        = la_x_p1;
  assign vid.la_y        = la_y_p1;

endmodule

// File: tb/tb_video_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_video_pattern_gen
// Bench for video_pattern_gen in the small test configuration (24x12 raster,
// 16x8 active, GRID 4, LOOKAHEAD 5). Two instances share stimulus: one with
// active-high syncs, one with active-low syncs. Expected outputs are derived
// from the raster position (edges since reset) with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_video_pattern_gen;

  localparam int H_ACT  = 16;
  localparam int H_FP   = 2;
  localparam int H_SYNC = 3;
  localparam int H_BP   = 3;
  localparam int V_ACT  = 8;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 1;
  localparam int GRID   = 4;
  localparam int LA     = 5;
  localparam int CNT_W  = 12;
  localparam int H_BL   = H_FP + H_SYNC + H_BP;
  localparam int H_T    = H_BL + H_ACT;
  localparam int V_BL   = V_FP + V_SYNC + V_BP;
  localparam int V_T    = V_BL + V_ACT;
  localparam int FT     = H_T * V_T;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;

  always #5 clk = ~clk;

  video_pattern_gen_if #(.CNT_W(CNT_W)) vid_a ();
  video_pattern_gen_if #(.CNT_W(CNT_W)) vid_b ();

  video_pattern_gen #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b1), .VS_POL(1'b1), .GRID(GRID), .LOOKAHEAD(LA), .CNT_W(CNT_W)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .solid_rgb(solid_rgb), .vid(vid_a)
  );

  video_pattern_gen #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0), .GRID(GRID), .LOOKAHEAD(LA), .CNT_W(CNT_W)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode), .solid_rgb(solid_rgb), .vid(vid_b)
  );

  wire [52:0] act_a = {vid_a.hs, vid_a.vs, vid_a.de, vid_a.frame_start,
                       vid_a.rgb_r, vid_a.rgb_g, vid_a.rgb_b,
                       vid_a.la_valid, vid_a.la_x, vid_a.la_y};
  wire [52:0] act_b = {vid_b.hs, vid_b.vs, vid_b.de, vid_b.frame_start,
                       vid_b.rgb_r, vid_b.rgb_g, vid_b.rgb_b,
                       vid_b.la_valid, vid_b.la_x, vid_b.la_y};
  wire [23:0] rgb_a = {vid_a.rgb_r, vid_a.rgb_g, vid_a.rgb_b};

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: edges since reset, and the pattern selection in force.
  int          cyc;
  logic [1:0]  m_mode, out_mode;
  logic [23:0] m_solid, out_solid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc       <= 0;
      m_mode    <= 2'd0;
      m_solid   <= 24'h0;
      out_mode  <= 2'd0;
      out_solid <= 24'h0;
    end else begin
      out_mode  <= m_mode;
      out_solid <= m_solid;
      if (cyc % FT == FT - 1) begin
        m_mode  <= mode;
        m_solid <= solid_rgb;
      end
      cyc <= cyc + 1;
    end
  end

  function automatic bit is_active(input int p);
    return (p % H_T >= H_BL) && ((p / H_T) % V_T >= V_BL);
  endfunction

  // Expected output bundle when raster position p is on the pins.
  function automatic logic [52:0] exp_vec(input int p, input logic [1:0] md,
                                          input logic [23:0] sol, input logic hp, input logic vp);
    int h, v, x, y, k, lx, ly;
    logic hs_e, vs_e, de_e, fs_e, lv_e;
    logic [23:0] c;
    h    = p % H_T;
    v    = (p / H_T) % V_T;
    hs_e = (h >= H_FP && h < H_FP + H_SYNC) ? hp : ~hp;
    vs_e = (v >= V_FP && v < V_FP + V_SYNC) ? vp : ~vp;
    de_e = is_active(p);
    x    = h - H_BL;
    y    = v - V_BL;
    c    = 24'h0;
    if (de_e) begin
      case (md)
        2'd0: begin
          k = x / (H_ACT / 8);
          if (k > 7) k = 7;
          c = BARS[k];
        end
        2'd1: c = (x % GRID == 0 || y % GRID == 0 || x == H_ACT - 1 || y == V_ACT - 1) ?
                  24'hFFFFFF : 24'h0;
        2'd2: c = {8'(x), 8'(y), 8'(x ^ y)};
        default: c = sol;
      endcase
    end
    fs_e = de_e && x == 0 && y == 0;
    lv_e = is_active(p + LA);
    lx = 0;
    ly = 0;
    for (int r = p + LA; r >= LA; r--) begin
      if (is_active(r)) begin
        lx = r % H_T - H_BL;
        ly = (r / H_T) % V_T - V_BL;
        break;
      end
    end
    return {hs_e, vs_e, de_e, fs_e, c, lv_e, 12'(lx), 12'(ly)};
  endfunction

  function automatic logic [52:0] exp_now(input logic hp, input logic vp);
    if (cyc == 0) return {~hp, ~vp, 51'b0};
    return exp_vec(cyc - 1, out_mode, out_solid, hp, vp);
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n     = 1'b0;
    mode      = 2'd0;
    solid_rgb = 24'h0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (act_a !== {2'b00, 51'b0}) begin
      n_fail++;
      $display("FAIL reset_a actual=%h required=%h", act_a, {2'b00, 51'b0});
    end
    n_chk++;
    if (act_b !== {2'b11, 51'b0}) begin
      n_fail++;
      $display("FAIL reset_b actual=%h required=%h", act_b, {2'b11, 51'b0});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_timing();
    int first_de = 0, runs = 0, run_len = 0, min_len = 1000, max_len = 0;
    int fs1 = 0, fs2 = 0, hs_n = 0, hs_first = 0, hsb_n = 0, hsb_first = 0;
    int vs_first = 0, vs_last = 0;
    logic prev_de = 1'b0;
    logic [23:0] exp_c;
    bit chk_c;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n_chk++;
      if (act_a !== exp_now(1'b1, 1'b1)) begin
        n_fail++;
        $display("FAIL timing_a cyc=%0d actual=%h required=%h", cyc, act_a, exp_now(1'b1, 1'b1));
      end
      n_chk++;
      if (act_b !== exp_now(1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL timing_b cyc=%0d actual=%h required=%h", cyc, act_b, exp_now(1'b0, 1'b0));
      end
      chk_c = 1'b1;
      case (cyc)
        104, 119, 120, 121: exp_c = 24'h000000;
        105, 106:           exp_c = 24'hFFFFFF;
        107, 108:           exp_c = 24'hFFFF00;
        default:            chk_c = 1'b0;
      endcase
      if (chk_c) begin
        n_chk++;
        if (rgb_a !== exp_c) begin
          n_fail++;
          $display("FAIL bars cyc=%0d actual=%h required=%h", cyc, rgb_a, exp_c);
        end
      end
      if (vid_a.de) run_len++;
      if (vid_a.de && !prev_de) begin
        if (first_de == 0) first_de = cyc;
        if (cyc <= FT) runs++;
      end
      if (!vid_a.de && prev_de) begin
        if (run_len < min_len) min_len = run_len;
        if (run_len > max_len) max_len = run_len;
        run_len = 0;
      end
      prev_de = vid_a.de;
      if (vid_a.frame_start) begin
        if (fs1 == 0) fs1 = cyc;
        else if (fs2 == 0) fs2 = cyc;
      end
      if (cyc <= H_T && vid_a.hs) begin
        hs_n++;
        if (hs_first == 0) hs_first = cyc;
      end
      if (cyc <= H_T && !vid_b.hs) begin
        hsb_n++;
        if (hsb_first == 0) hsb_first = cyc;
      end
      if (cyc <= FT && vid_a.vs) begin
        if (vs_first == 0) vs_first = cyc;
        vs_last = cyc;
      end
    end
    n_chk++; if (first_de !== 105) begin n_fail++; $display("FAIL first_de actual=%0d required=105", first_de); end
    n_chk++; if (runs !== 8) begin n_fail++; $display("FAIL de_runs actual=%0d required=8", runs); end
    n_chk++; if (min_len !== 16 || max_len !== 16) begin n_fail++; $display("FAIL run_len actual=%0d..%0d required=16", min_len, max_len); end
    n_chk++; if (fs1 !== 105) begin n_fail++; $display("FAIL fs_first actual=%0d required=105", fs1); end
    n_chk++; if (fs2 - fs1 !== FT) begin n_fail++; $display("FAIL frame_period actual=%0d required=%0d", fs2 - fs1, FT); end
    n_chk++; if (hs_first !== 3 || hs_n !== 3) begin n_fail++; $display("FAIL hs_pos actual=%0d/%0d required=3/3", hs_first, hs_n); end
    n_chk++; if (hsb_first !== 3 || hsb_n !== 3) begin n_fail++; $display("FAIL hs_pol actual=%0d/%0d required=3/3", hsb_first, hsb_n); end
    n_chk++; if (vs_first !== 25 || vs_last !== 72) begin n_fail++; $display("FAIL vs_pos actual=%0d..%0d required=25..72", vs_first, vs_last); end
  endtask

  task automatic test_grid();
    int n, p, x, y;
    logic [23:0] exp_c;
    mode = 2'd1;
    n = FT - (cyc % FT) + FT;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_chk++;
      if (act_a !== exp_now(1'b1, 1'b1)) begin
        n_fail++;
        $display("FAIL grid_a cyc=%0d actual=%h required=%h", cyc, act_a, exp_now(1'b1, 1'b1));
      end
      n_chk++;
      if (act_b !== exp_now(1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL grid_b cyc=%0d actual=%h required=%h", cyc, act_b, exp_now(1'b0, 1'b0));
      end
      p = (cyc - 1) % FT;
      x = p % H_T - H_BL;
      y = p / H_T - V_BL;
      if (out_mode == 2'd1 && vid_a.de && y <= 1) begin
        exp_c = (y == 0 || x == 0 || x == 4 || x == 8 || x == 12 || x == 15) ? 24'hFFFFFF : 24'h0;
        n_chk++;
        if (rgb_a !== exp_c) begin
          n_fail++;
          $display("FAIL grid_line x=%0d y=%0d actual=%h required=%h", x, y, rgb_a, exp_c);
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    int n;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      n_chk++;
      if (act_a !== exp_now(1'b1, 1'b1)) begin
        n_fail++;
        $display("FAIL switch_pre cyc=%0d actual=%h required=%h", cyc, act_a, exp_now(1'b1, 1'b1));
      end
    end
    mode = 2'd2;
    n = FT - (cyc % FT) + FT;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_chk++;
      if (act_a !== exp_now(1'b1, 1'b1)) begin
        n_fail++;
        $display("FAIL switch_a cyc=%0d actual=%h required=%h", cyc, act_a, exp_now(1'b1, 1'b1));
      end
      if (out_mode == 2'd2 && (cyc - 1) % FT == (V_BL + 5) * H_T + H_BL + 3) begin
        n_chk++;
        if (rgb_a !== 24'h030506) begin
          n_fail++;
          $display("FAIL gradient_x3y5 actual=%h required=030506", rgb_a);
        end
      end
    end
  endtask

  task automatic test_solid();
    int n;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_chk++;
      if (act_a !== exp_now(1'b1, 1'b1)) begin
        n_fail++;
        $display("FAIL solid_pre cyc=%0d actual=%h required=%h", cyc, act_a, exp_now(1'b1, 1'b1));
      end
    end
    mode      = 2'd3;
    solid_rgb = 24'h123456;
    n = FT - (cyc % FT) + FT;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_chk++;
      if (act_b !== exp_now(1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL solid_b cyc=%0d actual=%h required=%h", cyc, act_b, exp_now(1'b0, 1'b0));
      end
      if (out_mode == 2'd3 && vid_a.de) begin
        n_chk++;
        if (rgb_a !== 24'h123456) begin
          n_fail++;
          $display("FAIL solid_pix cyc=%0d actual=%h required=123456", cyc, rgb_a);
        end
      end
    end
  endtask

  task automatic test_lookahead();
    logic [24:0] laq[$];
    logic [24:0] old;
    int p, x, y;
    for (int i = 0; i < 3 * FT; i++) begin
      @(negedge clk);
      n_chk++;
      if (act_a !== exp_now(1'b1, 1'b1)) begin
        n_fail++;
        $display("FAIL la_model cyc=%0d actual=%h required=%h", cyc, act_a, exp_now(1'b1, 1'b1));
      end
      laq.push_back({vid_a.la_valid, vid_a.la_x, vid_a.la_y});
      if (laq.size() > LA) begin
        old = laq.pop_front();
        p = cyc - 1;
        x = p % H_T - H_BL;
        y = (p / H_T) % V_T - V_BL;
        n_chk++;
        if (old[24] !== vid_a.de) begin
          n_fail++;
          $display("FAIL la_delay_valid cyc=%0d actual=%b required=%b", cyc, old[24], vid_a.de);
        end
        if (vid_a.de) begin
          n_chk++;
          if (old[23:0] !== {12'(x), 12'(y)}) begin
            n_fail++;
            $display("FAIL la_delay_xy cyc=%0d actual=%h required=%h", cyc, old[23:0], {12'(x), 12'(y)});
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4 * FT; i++) begin
      @(negedge clk);
      n_chk++;
      if (act_a !== exp_now(1'b1, 1'b1)) begin
        n_fail++;
        $display("FAIL rand_a cyc=%0d actual=%h required=%h", cyc, act_a, exp_now(1'b1, 1'b1));
      end
      n_chk++;
      if (act_b !== exp_now(1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL rand_b cyc=%0d actual=%h required=%h", cyc, act_b, exp_now(1'b0, 1'b0));
      end
      // Changes land both exactly on the capture cycle and at arbitrary times.
      if ((cyc % FT == FT - 1 && $urandom_range(1, 0) == 1) || $urandom_range(40, 0) == 0) begin
        mode      = 2'($urandom_range(3, 0));
        solid_rgb = 24'($urandom);
      end
    end
  endtask

  task automatic test_reset_mid();
    int wait_n, first_de;
    wait_n = $urandom_range(700, 50);
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      n_chk++;
      if (act_a !== exp_now(1'b1, 1'b1)) begin
        n_fail++;
        $display("FAIL pre_rst cyc=%0d actual=%h required=%h", cyc, act_a, exp_now(1'b1, 1'b1));
      end
    end
    mode      = 2'd2;
    solid_rgb = 24'hABCDEF;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (act_a !== {2'b00, 51'b0}) begin
      n_fail++;
      $display("FAIL async_rst_a actual=%h required=%h", act_a, {2'b00, 51'b0});
    end
    n_chk++;
    if (act_b !== {2'b11, 51'b0}) begin
      n_fail++;
      $display("FAIL async_rst_b actual=%h required=%h", act_b, {2'b11, 51'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    first_de = 0;
    for (int i = 0; i < FT + 10; i++) begin
      @(negedge clk);
      n_chk++;
      if (act_a !== exp_now(1'b1, 1'b1)) begin
        n_fail++;
        $display("FAIL post_rst_a cyc=%0d actual=%h required=%h", cyc, act_a, exp_now(1'b1, 1'b1));
      end
      n_chk++;
      if (act_b !== exp_now(1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL post_rst_b cyc=%0d actual=%h required=%h", cyc, act_b, exp_now(1'b0, 1'b0));
      end
      if (vid_a.de && first_de == 0) first_de = cyc;
      if (cyc == 107) begin
        n_chk++;
        if (rgb_a !== 24'hFFFF00) begin
          n_fail++;
          $display("FAIL post_rst_mode0 actual=%h required=FFFF00", rgb_a);
        end
      end
    end
    n_chk++;
    if (first_de !== 105) begin
      n_fail++;
      $display("FAIL post_rst_first_de actual=%0d required=105", first_de);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_grid();
    test_mode_switch();
    test_solid();
    test_lookahead();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

Parametrised video timing and test-pattern generator; successor to the fixed-format colour-bar source. Timing is set by parameters, not compile-time defines. The block selects one of four patterns per frame and exports pixel coordinates with a configurable look-ahead, so downstream memory readers can prefetch. It sits at the head of the video pipeline and drives the display encoder directly.

## Interface
- H_ACTIVE, 1280, active pixels per line
- H_FP / H_SYNC / H_BP, 110 / 40 / 220, horizontal porch and sync widths (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP / V_SYNC / V_BP, 5 / 5 / 20, vertical porch and sync widths (lines)
- HS_POL / VS_POL, 1 / 1, asserted sync level
- GRID, 32, grid pitch in pixels for mode 1; power of two not required
- LOOKAHEAD, 0, cycles by which la_* lead de; 0 ≤ LOOKAHEAD < H_TOTAL·V_TOTAL
- CNT_W, 12, counter/coordinate width; H_TOTAL and V_TOTAL must each be < 2^CNT_W
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  pattern select: 0 bars, 1 grid, 2 gradient, 3 solid; sampled at frame boundary
- solid_rgb  in  24  {R,G,B} for mode 3; sampled with mode
- hs, vs, de  out  1  sync and data-enable
- rgb_r, rgb_g, rgb_b  out  8  pixel data
- frame_start  out  1  one-cycle pulse on first active pixel of each frame
- la_valid  out  1  equals de LOOKAHEAD cycles later
- la_x, la_y  out  CNT_W  coordinate of the pixel that appears LOOKAHEAD cycles later; held while la_valid=0

## Operation
- H_BLANK = H_FP+H_SYNC+H_BP, H_TOTAL = H_BLANK+H_ACTIVE; V_BLANK and V_TOTAL are defined the same way.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps, and wraps from V_TOTAL-1 to 0.
- Horizontal region order per line: FP [0,H_FP), SYNC [H_FP,H_FP+H_SYNC), BP, ACTIVE [H_BLANK,H_TOTAL). The vertical order is the same, in lines.
- hs = HS_POL while h_cnt is in SYNC, otherwise ~HS_POL. vs = VS_POL for whole lines with v_cnt in SYNC, otherwise ~VS_POL.
- de = h_cnt ≥ H_BLANK and v_cnt ≥ V_BLANK. x = h_cnt-H_BLANK, y = v_cnt-V_BLANK, both CNT_W bits.
- mode_r and solid_r load from mode and solid_rgb on the cycle where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1. The pattern never changes mid-frame.
- Mode 0, colour bars: bar width W = H_ACTIVE/8 (integer division). Bar k = min(x/W, 7) gives white, yellow, cyan, green, magenta, red, blue, black. Remainder pixels are black.
- Mode 1, grid: pixel is FFFFFF if x%GRID==0, y%GRID==0, x==H_ACTIVE-1 or y==V_ACTIVE-1; otherwise 000000. The modulo is implemented with phase counters, not dividers.
- Mode 2, gradient: r = x[7:0], g = y[7:0], b = x[7:0]^y[7:0].
- Mode 3, solid: rgb = solid_r.
- rgb = 0 whenever de=0.
- Look-ahead: a second counter pair (lh_cnt, lv_cnt) runs with the same wrap rules.
  - Its reset value is LOOKAHEAD positions ahead: lh = LOOKAHEAD % H_TOTAL, lv = (LOOKAHEAD / H_TOTAL) % V_TOTAL.
  - The positions carry correctly when lh exceeds H_TOTAL.
  - la_valid/la_x/la_y derive from the lead pair exactly as de/x/y derive from the main pair.

## Timing
- All outputs are registered. Outputs after clock edge k reflect the counter position held before edge k. Latency from counter to pins is 1 cycle.
- Reset values: h_cnt=v_cnt=0, lead pair at its offset, hs=~HS_POL, vs=~VS_POL, de=0, rgb=0, frame_start=0, la_valid=0, la_x=la_y=0, mode_r=0, solid_r=0.
- First edge after rst_n rises presents position (0,0).
- frame_start=1 exactly on the cycle de first rises with x=0, y=0.
- la_valid at cycle c equals de at cycle c+LOOKAHEAD, and la_x/la_y match the x/y shown then. This holds across line and frame wrap, including the first frame after reset.
- LOOKAHEAD=0: la_* equal de/x/y in the same cycle.
- Asynchronous reset mid-frame: all state returns to reset values immediately. The next frame restarts at position (0,0) with mode 0.
- A mode change at the sampling cycle takes effect on the first pixel of the next frame. Changes at any other time are ignored until the next sampling cycle.

## Test plan
Small configuration for all scenarios: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24); V_ACTIVE=8, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=12); GRID=4; LOOKAHEAD=5.
- Timing: release reset, count edges.
  - hs asserted on edges 3-5 of each line.
  - vs asserted from edge 25 through edge 72.
  - de first rises on edge 105.
  - 8 de runs of 16 per frame; frame period 288.
- Polarity: HS_POL=0, VS_POL=0. hs/vs idle high, pulse low with identical positions; reset values are 1.
- Bars (mode 0): x=0,1 FFFFFF; x=2,3 FFFF00; x=14,15 000000; blanking rgb=0.
- Grid (mode 1): line y=0 all FFFFFF. Line y=1: FFFFFF at x=0,4,8,12,15, 000000 elsewhere.
- Mode switch: mode=2 applied mid-frame; pattern changes only at the frame boundary. There (x=3, y=5) gives rgb = 03,05,06.
- Solid: mode=3, solid_rgb=123456 gives every active pixel 12,34,56.
- Look-ahead: for 3 frames, la_valid/la_x/la_y delayed by 5 equal de/x/y every cycle, including line and frame wrap.
- Reset mid-frame: assert rst_n low at a random cycle. Outputs go to reset values without waiting for a clock; the post-release sequence matches the timing test.
